control_multiciclo: RTL and testbench

// - Multicycle control unit for the microc datapath; replaces the single-cycle controller on the same interface.
// - Consumes Opcode/zero from the datapath; drives s_inc, s_inm, we, wez and ALUOp.
// - Adds the IR/PC load enables a multicycle datapath needs, so each instruction runs in 3 cycles.
// - Counts retired instructions for the microc bench.

---
 rtl/microc_pkg.sv | 37 +++
 rtl/control_decode.sv | 56 +++++
 rtl/control_multiciclo.sv | 120 ++++++++++++
 tb/tb_control_multiciclo.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/microc_pkg.sv
// Shared definitions for the microc multicycle controller and datapath:
// controller state encoding, opcode map and ALU function codes.
package microc_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        DECODE = 2'b01,
        EXEC   = 2'b10,
        TRAP   = 2'b11
    } state_t;

    localparam logic [5:0] OP_J   = 6'b000000;
    localparam logic [5:0] OP_JZ  = 6'b000001;
    localparam logic [5:0] OP_JNZ = 6'b000010;
    localparam logic [5:0] OP_LI  = 6'b010000;
    localparam logic [5:0] OP_ADI = 6'b010001;
    localparam logic [5:0] OP_SBI = 6'b010010;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_XOR  = 3'b111;

    // Function codes the datapath ALU implements for register-register ops.
    function automatic logic is_reg_alu_func(input logic [2:0] f);
        logic ok;
        ok = 1'b0;
        case (f)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decoder: latched opcode plus zero flag to the
// EXEC-phase datapath controls, with a flag for unmapped opcodes.
module control_decode
    import microc_pkg::*;
(
    input  logic [5:0] op,
    input  logic       zero,
    output logic       s_inc,
    output logic       s_inm,
    output logic       we,
    output logic       wez,
    output logic [2:0] alu_op,
    output logic       illegal
);

    always_comb begin
        s_inc   = 1'b1;
        s_inm   = 1'b0;
        we      = 1'b0;
        wez     = 1'b0;
        alu_op  = ALU_PASS;
        illegal = 1'b0;
        unique casez (op)
            OP_J:   s_inc = 1'b0;
            OP_JZ:  s_inc = ~zero;
            OP_JNZ: s_inc = zero;
            OP_LI: begin
                we    = 1'b1;
                s_inm = 1'b1;
            end
            OP_ADI: begin
                we     = 1'b1;
                wez    = 1'b1;
                s_inm  = 1'b1;
                alu_op = ALU_ADD;
            end
            OP_SBI: begin
                we     = 1'b1;
                wez    = 1'b1;
                s_inm  = 1'b1;
                alu_op = ALU_SUB;
            end
            6'b1?????: begin
                if (is_reg_alu_func(op[2:0])) begin
                    we     = 1'b1;
                    wez    = 1'b1;
                    alu_op = op[2:0];
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle microc control unit: FETCH -> DECODE -> EXEC per instruction, with a
// retired-instruction counter. Define CONTROL_ILLEGAL_TRAP_EN to trap on unmapped opcodes.
module control_multiciclo
    import microc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [5:0]       Opcode,
    input  logic             zero,
    output logic             ir_we,
    output logic             pc_we,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we,
    output logic             wez,
    output logic [2:0]       ALUOp,
    output logic             trap,
    output logic [CNT_W-1:0] instr_count
);

`ifdef CONTROL_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       dec_s_inc, dec_s_inm, dec_we, dec_wez, dec_illegal;
    logic [2:0] dec_alu_op;

    control_decode u_decode (
        .op      (op_q),
        .zero    (zero),
        .s_inc   (dec_s_inc),
        .s_inm   (dec_s_inm),
        .we      (dec_we),
        .wez     (dec_wez),
        .alu_op  (dec_alu_op),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            op_q    <= 6'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by reset so an asserted reset silences everything at once.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        s_inc   = 1'b1;
        s_inm   = 1'b0;
        we      = 1'b0;
        wez     = 1'b0;
        ALUOp   = ALU_PASS;
        trap    = 1'b0;
        if (reset) begin
            unique case (state_q)
                FETCH: begin
                    if (en) begin
                        ir_we   = 1'b1;
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    if (en) begin
                        op_d    = Opcode;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    if (TRAP_EN && dec_illegal) begin
                        if (en) begin
                            state_d = TRAP;
                        end
                    end else begin
                        // Unmapped opcodes reach here only as NOPs: decode yields no writes.
                        s_inc = dec_s_inc;
                        s_inm = dec_s_inm;
                        ALUOp = dec_alu_op;
                        if (en) begin
                            pc_we   = 1'b1;
                            we      = dec_we;
                            wez     = dec_wez;
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = FETCH;
                        end
                    end
                end
`ifdef CONTROL_ILLEGAL_TRAP_EN
                TRAP: begin
                    trap = 1'b1;
                end
`endif
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// Self-checking bench for control_multiciclo (default build): directed table,
// multi-cycle corner sequences and randomized stimulus against a phase-level model.
module tb_control_multiciclo;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [5:0]  Opcode;
    logic        zero;

    logic        ir_we, pc_we, s_inc, s_inm, we, wez, trap;
    logic [2:0]  ALUOp;
    logic [15:0] instr_count;

    logic        ir_we_b, pc_we_b, s_inc_b, s_inm_b, we_b, wez_b, trap_b;
    logic [2:0]  ALUOp_b;
    logic [3:0]  instr_count_b;

    control_multiciclo #(.CNT_W(16)) dut (
        .clk (clk), .reset (reset), .en (en), .Opcode (Opcode), .zero (zero),
        .ir_we (ir_we), .pc_we (pc_we), .s_inc (s_inc), .s_inm (s_inm), .we (we),
        .wez (wez), .ALUOp (ALUOp), .trap (trap), .instr_count (instr_count)
    );

    control_multiciclo #(.CNT_W(4)) dut_b (
        .clk (clk), .reset (reset), .en (en), .Opcode (Opcode), .zero (zero),
        .ir_we (ir_we_b), .pc_we (pc_we_b), .s_inc (s_inc_b), .s_inm (s_inm_b), .we (we_b),
        .wez (wez_b), .ALUOp (ALUOp_b), .trap (trap_b), .instr_count (instr_count_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: position within the 3-cycle instruction, latched opcode, retired count.
    int          phase;
    logic [5:0]  mop;
    int unsigned mcount;

    localparam logic [9:0] RST_OUTS = 10'b0010000000;

    typedef struct packed {
        logic [5:0] op;
        logic       z;
        logic [6:0] exp;  // {s_inc, s_inm, we, wez, ALUOp}
    } vec_t;

    vec_t tbl [13];

    logic [5:0] pool [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] dut_outs();
        return {ir_we, pc_we, s_inc, s_inm, we, wez, ALUOp, trap};
    endfunction

    function automatic logic [9:0] dut_outs_b();
        return {ir_we_b, pc_we_b, s_inc_b, s_inm_b, we_b, wez_b, ALUOp_b, trap_b};
    endfunction

    function automatic logic [9:0] model_outs(int ph, logic [5:0] op, logic z, logic e);
        logic ir, pc, inc, inm, w, wz;
        logic [2:0] alu;
        ir = 0; pc = 0; inc = 1; inm = 0; w = 0; wz = 0; alu = 3'd0;
        if (ph == 0) begin
            ir = e;
        end else if (ph == 2) begin
            pc = e;
            case (op)
                6'b000000: inc = 1'b0;
                6'b000001: inc = !z;
                6'b000010: inc = z;
                6'b010000: begin w = e; inm = 1; end
                6'b010001: begin w = e; wz = e; inm = 1; alu = 3'd2; end
                6'b010010: begin w = e; wz = e; inm = 1; alu = 3'd3; end
                default: begin
                    if (op[5] && (op[2:0] inside {3'd2, 3'd3, 3'd4, 3'd5, 3'd7})) begin
                        w = e; wz = e; alu = op[2:0];
                    end
                end
            endcase
        end
        return {ir, pc, inc, inm, w, wz, alu, 1'b0};
    endfunction

    task automatic model_reset();
        phase  = 0;
        mop    = 6'd0;
        mcount = 0;
    endtask

    task automatic cycle(input logic e, input logic [5:0] op, input logic z, input string tag);
        @(negedge clk);
        en = e; Opcode = op; zero = z;
        #1;
        check({tag, " outs"}, 32'(dut_outs()), 32'(model_outs(phase, mop, z, e)));
        check({tag, " outs_b"}, 32'(dut_outs_b()), 32'(model_outs(phase, mop, z, e)));
        check({tag, " count"}, 32'(instr_count), mcount & 32'hffff);
        check({tag, " count4"}, 32'(instr_count_b), mcount & 32'hf);
        if (e) begin
            if (phase == 1) mop = op;
            if (phase == 2) mcount++;
            phase = (phase + 1) % 3;
        end
    endtask

    initial begin
        tbl[0]  = '{op: 6'b010000, z: 1'b0, exp: 7'b1110000};
        tbl[1]  = '{op: 6'b010001, z: 1'b1, exp: 7'b1111010};
        tbl[2]  = '{op: 6'b010010, z: 1'b0, exp: 7'b1111011};
        tbl[3]  = '{op: 6'b100010, z: 1'b0, exp: 7'b1011010};
        tbl[4]  = '{op: 6'b101011, z: 1'b1, exp: 7'b1011011};
        tbl[5]  = '{op: 6'b110100, z: 1'b0, exp: 7'b1011100};
        tbl[6]  = '{op: 6'b111101, z: 1'b0, exp: 7'b1011101};
        tbl[7]  = '{op: 6'b100111, z: 1'b1, exp: 7'b1011111};
        tbl[8]  = '{op: 6'b000000, z: 1'b1, exp: 7'b0000000};
        tbl[9]  = '{op: 6'b000001, z: 1'b1, exp: 7'b0000000};
        tbl[10] = '{op: 6'b000001, z: 1'b0, exp: 7'b1000000};
        tbl[11] = '{op: 6'b000010, z: 1'b1, exp: 7'b1000000};
        tbl[12] = '{op: 6'b000010, z: 1'b0, exp: 7'b0000000};

        pool = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
                 6'b100010, 6'b101011, 6'b110100, 6'b111101, 6'b100111, 6'b000001,
                 6'b000010, 6'b001111, 6'b000011, 6'b011010};

        // Reset held for two cycles.
        reset = 1'b0; en = 1'b0; Opcode = 6'd0; zero = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset outs", 32'(dut_outs()), 32'(RST_OUTS));
        check("reset count", 32'(instr_count), 32'd0);
        reset = 1'b1;

        // LI right after release: fetch, idle decode, execute.
        cycle(1'b1, 6'b010000, 1'b0, "li c1");
        check("li c1 exact", 32'(dut_outs()), 32'(10'b1010000000));
        cycle(1'b1, 6'b010000, 1'b0, "li c2");
        check("li c2 exact", 32'(dut_outs()), 32'(RST_OUTS));
        cycle(1'b1, 6'b010000, 1'b0, "li c3");
        check("li c3 exact", 32'(dut_outs()), 32'(10'b0111100000));
        @(posedge clk);
        #1;
        check("li retired", 32'(instr_count), 32'd1);

        // Directed opcode table.
        for (int i = 0; i < 13; i++) begin
            repeat (3) cycle(1'b1, tbl[i].op, tbl[i].z, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d exec", i), 32'({s_inc, s_inm, we, wez, ALUOp}),
                  32'(tbl[i].exp));
            check($sformatf("tbl%0d pc_we", i), 32'(pc_we), 32'd1);
        end

        // Stall five cycles in DECODE with a different opcode on the bus.
        cycle(1'b1, 6'b100111, 1'b0, "stall fetch");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 6'b010000, 1'b1, "stall hold");
            check("stall enables", 32'({ir_we, pc_we, we, wez}), 32'd0);
        end
        cycle(1'b1, 6'b100111, 1'b0, "stall decode");
        cycle(1'b1, 6'b100111, 1'b0, "stall exec");
        check("stall exec xor", 32'({we, wez, s_inm, ALUOp}), 32'(6'b110111));

        // Asynchronous reset between edges while in EXEC.
        cycle(1'b1, 6'b100010, 1'b0, "abort fetch");
        cycle(1'b1, 6'b100010, 1'b0, "abort decode");
        @(negedge clk);
        en = 1'b1;
        #1;
        check("abort pre we", 32'({pc_we, we}), 32'(2'b11));
        #1;
        reset = 1'b0;
        #1;
        check("abort outs", 32'(dut_outs()), 32'(RST_OUTS));
        check("abort count", 32'(instr_count), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Sixteen instructions wrap the 4-bit counter; first cycle must be FETCH.
        for (int i = 0; i < 48; i++) begin
            cycle(1'b1, 6'b010001, 1'b0, "wrap");
        end
        @(posedge clk);
        #1;
        check("wrap count16", 32'(instr_count), 32'd16);
        check("wrap count4", 32'(instr_count_b), 32'd0);

        // Randomized stimulus with stalls, jumps, NOPs and a wandering zero flag.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), pool[$urandom_range(0, 15)],
                  1'($urandom_range(0, 1)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
